mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 20 ++
 rtl/mac_sequencer_adder_8_bit.sv | 22 ++
 rtl/mac_sequencer.sv | 122 ++++++++++++
 tb/tb_mac_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared MAC constants: FSM state encoding, multiply cycle count and
// operand/accumulator widths. Other MAC blocks import this package so
// the encodings and widths stay consistent across the family.
package mac_sequencer_pkg;

  localparam int unsigned MAC_OP_W        = 4;  // operand width
  localparam int unsigned MAC_ACC_W       = 8;  // accumulator / product width
  localparam int unsigned MAC_MULT_CYCLES = 4;  // one cycle per multiplier bit
  localparam int unsigned MAC_IDX_W       = 2;  // bit index counter width

  localparam logic [MAC_IDX_W-1:0] MAC_IDX_LAST = MAC_IDX_W'(MAC_MULT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_ACC  = 2'b10,
    ST_DONE = 2'b11
  } mac_state_e;

endpackage

// File: rtl/mac_sequencer_adder_8_bit.sv
// adder_8_bit: the single 8-bit adder time-shared by the MAC sequencer.
// Ports:
//   a_lo_i [3:0]  low nibble of operand A
//   a_hi_i [3:0]  high nibble of operand A
//   b_i    [7:0]  operand B
//   sum_o  [7:0]  (A + B) mod 256
//   cout_o        carry-out of the 8-bit addition
module adder_8_bit
  import mac_sequencer_pkg::*;
(
  input  logic [MAC_OP_W-1:0]  a_lo_i,
  input  logic [MAC_OP_W-1:0]  a_hi_i,
  input  logic [MAC_ACC_W-1:0] b_i,
  output logic [MAC_ACC_W-1:0] sum_o,
  output logic                 cout_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_hi_i, a_lo_i} + {1'b0, b_i};
  end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: shift-and-add 4x4 unsigned multiplier feeding an 8-bit
// accumulator with a sticky overflow flag. One adder is shared between the
// partial-product build (MULT, 4 cycles) and the accumulate (ACC, 1 cycle).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a multiply-accumulate (sampled in IDLE only)
//   clear_acc  zero acc and overflow (sampled in IDLE only)
//   op_a/op_b  4-bit unsigned operands, captured when start is accepted
//   busy       high in MULT and ACC
//   done       one-cycle pulse in DONE
//   acc        registered accumulator
//   overflow   sticky accumulate carry-out
module mac_sequencer
  import mac_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear_acc,
  input  logic [MAC_OP_W-1:0]  op_a,
  input  logic [MAC_OP_W-1:0]  op_b,
  output logic                 busy,
  output logic                 done,
  output logic [MAC_ACC_W-1:0] acc,
  output logic                 overflow
);

  mac_state_e               state_q, state_d;
  logic [MAC_OP_W-1:0]      a_q, b_q;
  logic [MAC_IDX_W-1:0]     idx_q;
  logic [MAC_ACC_W-1:0]     partial_q;
  logic [MAC_ACC_W-1:0]     acc_q;
  logic                     ovf_q;

  logic [MAC_ACC_W-1:0]     add_a, add_b, add_sum;
  logic                     add_cout;

  // Operand mux for the shared adder. In MULT the B input is the latched
  // multiplicand shifted to the current bit position, gated by that
  // multiplier bit; a zero bit adds zero so partial is unchanged.
  always_comb begin
    add_a = partial_q;
    add_b = '0;
    if (state_q == ST_ACC) begin
      add_a = acc_q;
      add_b = partial_q;
    end else if (b_q[idx_q]) begin
      add_b = {{(MAC_ACC_W-MAC_OP_W){1'b0}}, a_q} << idx_q;
    end
  end

  adder_8_bit u_adder (
    .a_lo_i (add_a[MAC_OP_W-1:0]),
    .a_hi_i (add_a[MAC_ACC_W-1:MAC_OP_W]),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_MULT;
      ST_MULT: if (idx_q == MAC_IDX_LAST) state_d = ST_ACC;
      ST_ACC:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      partial_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Clear and start may coincide: the clear lands first, so the
          // following ACC adds onto zero.
          if (clear_acc) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (start) begin
            a_q       <= op_a;
            b_q       <= op_b;
            partial_q <= '0;
            idx_q     <= '0;
          end
        end
        ST_MULT: begin
          partial_q <= add_sum;
          idx_q     <= idx_q + 1'b1;  // wraps to 0 after the last bit
        end
        ST_ACC: begin
          acc_q <= add_sum;
          if (add_cout) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == ST_MULT) || (state_q == ST_ACC);
  assign done     = (state_q == ST_DONE);
  assign acc      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear_acc = 1'b0;
  logic [3:0] op_a = '0;
  logic [3:0] op_b = '0;
  logic       busy, done, overflow;
  logic [7:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   model_acc = 0;
  bit   model_ovf = 1'b0;

  mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear_acc (clear_acc),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .acc       (acc),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference model: the accumulator is plain integer arithmetic on a*b.
  task automatic model_accept(input int a, input int b, input bit clr);
    if (clr) begin
      model_acc = 0;
      model_ovf = 1'b0;
    end
    model_acc = model_acc + a * b;
    if (model_acc > 255) begin
      model_ovf = 1'b1;
      model_acc = model_acc - 256;
    end
    exp_q.push_back('{model_acc, model_ovf});
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with acc=%0d, expected no done", acc);
      end else begin
        e = exp_q.pop_front();
        $display("txn done: acc=%0d ovf=%0d (expected acc=%0d ovf=%0d)", acc, overflow, e.acc, e.ovf);
        check("done_acc", acc, e.acc);
        check("done_ovf", overflow, e.ovf);
      end
    end
  end

  // Issue one operation from IDLE and wait (bounded) for its done pulse.
  // spam keeps start high throughout, including the edge sampled in DONE;
  // scramble changes the operand inputs every cycle after acceptance.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input bit clr, input bit spam, input bit scramble);
    bit seen;
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    clear_acc = clr;
    @(posedge clk);
    model_accept(a, b, clr);
    #1;
    start     = spam;
    clear_acc = spam ? 1'b1 : 1'b0;
    seen      = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_accept", busy, 1);
      if (done === 1'b1) begin
        seen = 1'b1;
        check("done_latency", cyc, 6);
        check("busy_in_done", busy, 0);
      end else if (scramble || spam) begin
        op_a = 4'($urandom);
        op_b = 4'($urandom);
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 20 cycles, expected done after 6");
    end
    // Edge where the DUT is in DONE: start/clear here must be ignored.
    @(posedge clk);
    #1;
    start     = 1'b0;
    clear_acc = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_acc = 1'b1;
    @(posedge clk);
    model_acc = 0;
    model_ovf = 1'b0;
    #1;
    clear_acc = 1'b0;
    @(negedge clk);
    check("clear_acc_value", acc, 0);
    check("clear_ovf_value", overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("reset_acc", acc, 0);
    check("reset_ovf", overflow, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3x5 straight out of reset
    do_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    check("op3x5_acc", acc, 15);
    check("op3x5_ovf", overflow, 0);

    // Chain to wrap: 225, 240, then 240+16 wraps to 0 with overflow; sticky after 1x1
    do_clear();
    do_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
    check("chain1_acc", acc, 225);
    do_op(4'd15, 4'd1, 1'b0, 1'b0, 1'b0);
    check("chain2_acc", acc, 240);
    do_op(4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    check("chain3_acc", acc, 0);
    check("chain3_ovf", overflow, 1);
    do_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("sticky_acc", acc, 1);
    check("sticky_ovf", overflow, 1);

    // 2x2 with start (and clear) held high while busy and in DONE
    do_clear();
    do_op(4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("spam_acc", acc, 4);
    check("spam_busy_idle", busy, 0);

    // Reset in the middle of MULT for 7x7 with acc=10
    do_clear();
    do_op(4'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    check("pre_reset_acc", acc, 10);
    @(negedge clk);
    op_a  = 4'd7;
    op_b  = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_acc = 0;
    model_ovf = 1'b0;
    check("midrst_acc", acc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("postrst_acc", acc, 0);
    do_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("postrst_1x1", acc, 1);

    // acc=50 then clear together with start of 4x0
    do_clear();
    do_op(4'd5, 4'd10, 1'b0, 1'b0, 1'b0);
    check("pre_clr_acc", acc, 50);
    do_op(4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
    check("clr_start_acc", acc, 0);
    check("clr_start_ovf", overflow, 0);

    // 9x3 with operands scrambled after acceptance
    do_clear();
    do_op(4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    do_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b1);
    check("scramble_acc", acc, 33);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      do_op(4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_acc", acc, model_acc);
    check("final_ovf", overflow, model_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
